calc1_scoreboard: RTL
=====================

Name: calc1_scoreboard

Overview:
- Passive monitor that sits alongside the calc1 DUV in the testbench and consumes the DUV's per-port command inputs and response outputs.
- Tracks one outstanding request per port (ports 1-4) and measures response latency.
- Flags protocol violations, timeouts and starvation (one port repeatedly passed over while others complete), giving the bench a fairness view the data checker does not provide.

Parameters:
- LAT_W, 8: width of the latency counters; saturate at 2^LAT_W-1.
- CNT_W, 16: width of the completed-request counters; wrap-around.
- TIMEOUT, 200: latency (cycles) at which an outstanding request is flagged.
- STARVE_LIM, 8: number of other-port completions tolerated while a port waits.

Ports:
- c_clk  in  1  testbench clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- test_change  in  1  synchronous clear of statistics and sticky errors at test boundaries.
- req_cmd_bus  in  16  port p command at bits [4(p-1) +: 4] (port 1 lowest); 0 = no-op.
- out_resp_bus  in  8  port p response at bits [2(p-1) +: 2]; 0 = none, 1 = success, 2 = invalid/overflow, 3 = internal error.
- busy  out  4  bit p-1 set while port p has an outstanding request.
- err_proto  out  4  sticky per-port protocol error.
- err_timeout  out  4  sticky per-port timeout.
- err_starve  out  4  sticky per-port starvation.
- max_lat_bus  out  4*LAT_W  per-port maximum observed latency.
- done_cnt_bus  out  4*CNT_W  per-port completed-request count.

Behaviour:
- Reset: every output is 0, every port is IDLE, all internal counters are 0. Reset takes priority over everything, including mid-request; the request being tracked is discarded.
- Per-port FSM, IDLE / WAIT:
  - IDLE, cmd!=0 → WAIT; lat<=0; starve<=0.
  - IDLE, resp!=0 → err_proto set; stays IDLE.
  - WAIT, resp==0 → lat<=sat(lat+1).
  - WAIT, resp!=0 → completion.
- Completion, for a response sampled n edges after the issue edge:
  - Recorded latency is n, which equals lat+1.
  - max_lat <= max(max_lat, n); done_cnt <= done_cnt+1.
  - Next state is IDLE unless cmd!=0 on the same edge. In that case the new command is a legal back-to-back issue: stay WAIT, lat<=0.
- WAIT, cmd!=0 with resp==0: err_proto set. The original request stays tracked and lat is not reset.
- Timeout: in WAIT, if lat+1 == TIMEOUT with no response, err_timeout is set. The port remains WAIT, and a later response completes normally.
- Starvation:
  - For each port in WAIT with no own response this edge, starve += number of other ports completing this edge (0-3); starve saturates.
  - err_starve is set when starve reaches STARVE_LIM or more.
- Sticky flags clear only on reset or test_change.
- test_change:
  - Clears err_*, max_lat, done_cnt and starve.
  - FSM state and lat are preserved, so in-flight requests are still tracked.
  - If test_change coincides with a completion, the clear wins and the completion is not counted.
- busy reflects the registered FSM state (1-cycle visibility after issue).
- The block never drives DUV inputs.

Optional Feature:
- Macro: CALC1_SB_DISPLAY_EN.
- Defined: each error-flag set event and each completion prints $time, port number, response code and latency via $display.
- Undefined: no console output; signal behaviour is identical in both builds.

Decomposition:
- Shared package calc1_sb_pkg holds:
  - command encodings (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6);
  - response encodings (NONE=0, OK=1, INV=2, ERR=3);
  - the FSM state typedef (IDLE/WAIT);
  - NUM_PORTS=4.
- One sub-module, calc1_sb_port: the per-port FSM plus lat, max_lat, done_cnt, starve and sticky flags, with a 2-bit "other completions" input. It is instantiated 4 times with a generate loop.
- The top level computes each port's other-completion count from the four completion strobes.

Test Plan:
- Port 1: cmd=1 at edge 10, resp=1 at edge 14 → busy[0]=1 for edges 11-14; max_lat(1)=4; done_cnt(1)=1; no errors.
- Port 2: resp=2 while IDLE → err_proto[1]=1; busy[1] stays 0; done_cnt(2)=0.
- Port 3: cmd issued, no response for 200 edges → err_timeout[2]=1 at issue+200; a response at issue+205 gives done_cnt(3)=1 and max_lat(3)=205.
- Port 4 waiting while ports 1-3 complete 3 requests each (9 completions) → err_starve[3]=1 once starve reaches 8; no other port flags.
- Port 1: response and new cmd on the same edge → done_cnt increments, busy[0] stays 1, err_proto[0]=0; the next latency is measured from that edge.
- Errors set, then test_change pulsed while port 2 is in WAIT → all err_*, max_lat and done_cnt read 0; busy[1] stays 1; the later response gives done_cnt(2)=1. Assert reset mid-WAIT → all outputs 0 the next cycle.

Source files
------------

// File: rtl/calc1_sb_pkg.sv
// Shared encodings, FSM state type and port count for the calc1 scoreboard.
// Optional console trace: CALC1_SB_DISPLAY_EN (see calc1_sb_port).
package calc1_sb_pkg;

  localparam int NUM_PORTS = 4;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_t;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_INV  = 2'd2,
    RESP_ERR  = 2'd3
  } resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Number of ports other than 'self' completing this edge (0..NUM_PORTS-1).
  function automatic logic [1:0] other_count(input logic [NUM_PORTS-1:0] cmp, input int self);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (i != self && cmp[i]) n = n + 3'd1;
    end
    return n[1:0];
  endfunction

endpackage

// File: rtl/calc1_sb_port.sv
// Per-port tracker: IDLE/WAIT FSM, latency, completion count, starvation and sticky errors.
// Registered outputs, completion strobe is combinational; CALC1_SB_DISPLAY_EN adds a console trace.
module calc1_sb_port
  import calc1_sb_pkg::*;
#(
  parameter int LAT_W      = 8,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 200,
  parameter int STARVE_LIM = 8
`ifdef CALC1_SB_DISPLAY_EN
  ,
  parameter int PORT_ID    = 1
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             test_change,
  input  logic [3:0]       cmd,
  input  logic [1:0]       resp,
  input  logic [1:0]       other_cmp,
  output logic             busy,
  output logic             cmp,
  output logic             err_proto,
  output logic             err_timeout,
  output logic             err_starve,
  output logic [LAT_W-1:0] max_lat,
  output logic [CNT_W-1:0] done_cnt
);

  // Headroom so one edge of up to three other completions cannot wrap past the limit.
  localparam int STV_W = $clog2(STARVE_LIM + 4);

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat, lat_nxt, lat_inc, max_lat_nxt;
  logic [CNT_W-1:0]   done_nxt;
  logic [STV_W-1:0]   starve, starve_nxt, starve_sat;
  logic [STV_W:0]     starve_sum;
  logic               proto_nxt, tmo_nxt, stv_nxt;
  logic               has_cmd, has_resp, timeout_hit, starve_hit;

  assign has_cmd     = (cmd != CMD_NOP);
  assign has_resp    = (resp != RESP_NONE);
  assign lat_inc     = (lat == {LAT_W{1'b1}}) ? lat : lat + LAT_W'(1);
  assign timeout_hit = ((32'(lat) + 32'd1) == 32'(TIMEOUT));
  assign starve_sum  = {1'b0, starve} + (STV_W + 1)'(other_cmp);
  assign starve_sat  = starve_sum[STV_W] ? {STV_W{1'b1}} : starve_sum[STV_W-1:0];
  assign starve_hit  = (32'(starve_sat) >= 32'(STARVE_LIM));
  assign busy        = (state == WAIT);

  always_comb begin
    state_nxt   = state;
    lat_nxt     = lat;
    max_lat_nxt = max_lat;
    done_nxt    = done_cnt;
    starve_nxt  = starve;
    proto_nxt   = err_proto;
    tmo_nxt     = err_timeout;
    stv_nxt     = err_starve;
    cmp         = 1'b0;
    case (state)
      IDLE: begin
        if (has_resp) proto_nxt = 1'b1;
        if (has_cmd) begin
          state_nxt  = WAIT;
          lat_nxt    = '0;
          starve_nxt = '0;
        end
      end
      WAIT: begin
        if (has_resp) begin
          // Recorded latency is lat+1: edges since the issue edge.
          cmp      = 1'b1;
          done_nxt = done_cnt + CNT_W'(1);
          if (lat_inc > max_lat) max_lat_nxt = lat_inc;
          if (has_cmd) lat_nxt = '0;
          else         state_nxt = IDLE;
        end else begin
          lat_nxt    = lat_inc;
          starve_nxt = starve_sat;
          if (timeout_hit) tmo_nxt   = 1'b1;
          if (starve_hit)  stv_nxt   = 1'b1;
          if (has_cmd)     proto_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Test boundary: statistics restart, in-flight tracking survives.
    if (test_change) begin
      max_lat_nxt = '0;
      done_nxt    = '0;
      starve_nxt  = '0;
      proto_nxt   = 1'b0;
      tmo_nxt     = 1'b0;
      stv_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat         <= '0;
      max_lat     <= '0;
      done_cnt    <= '0;
      starve      <= '0;
      err_proto   <= 1'b0;
      err_timeout <= 1'b0;
      err_starve  <= 1'b0;
    end else begin
      state       <= state_nxt;
      lat         <= lat_nxt;
      max_lat     <= max_lat_nxt;
      done_cnt    <= done_nxt;
      starve      <= starve_nxt;
      err_proto   <= proto_nxt;
      err_timeout <= tmo_nxt;
      err_starve  <= stv_nxt;
    end
  end

`ifdef CALC1_SB_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (cmp && !test_change)
        $display("%0t calc1_sb port %0d: completion resp=%0d lat=%0d", $time, PORT_ID, resp, lat_inc);
      if (proto_nxt && !err_proto)
        $display("%0t calc1_sb port %0d: protocol error resp=%0d lat=%0d", $time, PORT_ID, resp, lat);
      if (tmo_nxt && !err_timeout)
        $display("%0t calc1_sb port %0d: timeout resp=%0d lat=%0d", $time, PORT_ID, resp, lat_inc);
      if (stv_nxt && !err_starve)
        $display("%0t calc1_sb port %0d: starvation resp=%0d lat=%0d", $time, PORT_ID, resp, lat_inc);
    end
  end
`endif

endmodule

// File: rtl/calc1_scoreboard.sv
// Passive calc1 monitor: four per-port trackers plus cross-port completion counting for fairness.
// Never drives the DUV; CALC1_SB_DISPLAY_EN enables the per-port console trace.
module calc1_scoreboard
  import calc1_sb_pkg::*;
#(
  parameter int LAT_W      = 8,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 200,
  parameter int STARVE_LIM = 8
) (
  input  logic                   c_clk,
  input  logic                   reset,
  input  logic                   test_change,
  input  logic [15:0]            req_cmd_bus,
  input  logic [7:0]             out_resp_bus,
  output logic [3:0]             busy,
  output logic [3:0]             err_proto,
  output logic [3:0]             err_timeout,
  output logic [3:0]             err_starve,
  output logic [4*LAT_W-1:0]     max_lat_bus,
  output logic [4*CNT_W-1:0]     done_cnt_bus
);

  logic [NUM_PORTS-1:0]      cmp;
  logic [NUM_PORTS-1:0][1:0] other;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) other[p] = other_count(cmp, p);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc1_sb_port #(
      .LAT_W      (LAT_W),
      .CNT_W      (CNT_W),
      .TIMEOUT    (TIMEOUT),
      .STARVE_LIM (STARVE_LIM)
`ifdef CALC1_SB_DISPLAY_EN
      ,
      .PORT_ID    (p + 1)
`endif
    ) u_port (
      .clk         (c_clk),
      .reset       (reset),
      .test_change (test_change),
      .cmd         (req_cmd_bus[4*p +: 4]),
      .resp        (out_resp_bus[2*p +: 2]),
      .other_cmp   (other[p]),
      .busy        (busy[p]),
      .cmp         (cmp[p]),
      .err_proto   (err_proto[p]),
      .err_timeout (err_timeout[p]),
      .err_starve  (err_starve[p]),
      .max_lat     (max_lat_bus[LAT_W*p +: LAT_W]),
      .done_cnt    (done_cnt_bus[CNT_W*p +: CNT_W])
    );
  end

endmodule
